// File: rtl/pc_gen_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_gen_unit : pre-IF fetch PC generator with prioritised redirects and    |
// |               an IF-stage register that tags wrong-path instructions.     |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module pc_gen_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h1c000000,
  parameter int unsigned       FETCH_BYTES = 4,
  parameter int unsigned       NUM_REDIR   = 3,
  parameter int unsigned       EX_W        = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic [ADDR_W-1:0]           req_pc_o,
  output logic                        req_adef_o,
  input  logic [EX_W-1:0]             inst_ex_i,
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_target_i,
  input  logic                        if_leave_i,
  output logic                        if_valid_o,
  output logic [ADDR_W-1:0]           if_pc_o,
  output logic [EX_W:0]               if_ex_o,
  output logic                        if_stale_o,
  output logic                        redir_pending_o
);

  localparam int unsigned       IDX_W      = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(FETCH_BYTES - 1);

  logic                req_valid_q;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                pend_v_q, pend_v_d;
  logic [IDX_W-1:0]    pend_idx_q, pend_idx_d;
  logic [ADDR_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic                if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [EX_W:0]       if_ex_q, if_ex_d;
  logic                if_stale_q, if_stale_d;

  logic                fire;
  logic                redir_any;
  logic [IDX_W-1:0]    sel_idx;
  logic [ADDR_W-1:0]   sel_tgt;
  logic [ADDR_W-1:0]   seq_pc;

  assign fire      = req_valid_q & req_ready_i;
  assign redir_any = |redir_valid_i;
  assign seq_pc    = (fetch_pc_q & ~ALIGN_MASK) + ADDR_W'(FETCH_BYTES);

  // Scan high to low so the lowest-indexed valid channel wins.
  always_comb begin
    sel_idx = '0;
    sel_tgt = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid_i[i]) begin
        sel_idx = IDX_W'(i);
        sel_tgt = redir_target_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_v_d   = pend_v_q;
    pend_idx_d = pend_idx_q;
    pend_tgt_d = pend_tgt_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_ex_d    = if_ex_q;
    if_stale_d = if_stale_q;
    if (fire) begin
      if (redir_any)     fetch_pc_d = sel_tgt;
      else if (pend_v_q) fetch_pc_d = pend_tgt_q;
      else               fetch_pc_d = seq_pc;
      pend_v_d   = 1'b0;
      if_valid_d = 1'b1;
      if_pc_d    = fetch_pc_q;
      if_ex_d    = {req_adef_o, inst_ex_i};
      if_stale_d = redir_any | pend_v_q;
    end else begin
      // An equal-or-higher priority redirect overwrites the buffered one.
      if (redir_any && (!pend_v_q || (sel_idx <= pend_idx_q))) begin
        pend_v_d   = 1'b1;
        pend_idx_d = sel_idx;
        pend_tgt_d = sel_tgt;
      end
      if (if_leave_i) begin
        if_valid_d = 1'b0;
        if_stale_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      pend_v_q    <= 1'b0;
      pend_idx_q  <= '0;
      pend_tgt_q  <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_ex_q     <= '0;
      if_stale_q  <= 1'b0;
    end else begin
      req_valid_q <= 1'b1;
      fetch_pc_q  <= fetch_pc_d;
      pend_v_q    <= pend_v_d;
      pend_idx_q  <= pend_idx_d;
      pend_tgt_q  <= pend_tgt_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_ex_q     <= if_ex_d;
      if_stale_q  <= if_stale_d;
    end
  end

  assign req_valid_o     = req_valid_q;
  assign req_pc_o        = fetch_pc_q;
  assign req_adef_o      = (fetch_pc_q[1:0] != 2'b00);
  assign if_valid_o      = if_valid_q;
  assign if_pc_o         = if_pc_q;
  assign if_ex_o         = if_ex_q;
  assign if_stale_o      = if_stale_q;
  assign redir_pending_o = pend_v_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_gen_unit : two instances (4- and 16-byte fetch) driven in lockstep  |
// |                  and compared against a per-cycle behavioural model.      |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_pc_gen_unit;
  localparam int AW = 32;
  localparam int NR = 3;
  localparam int EW = 2;
  localparam logic [AW-1:0] RPC = 32'h1c000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             req_ready_i = 1'b0;
  logic [EW-1:0]    inst_ex_i = '0;
  logic [NR-1:0]    redir_valid_i = '0;
  logic [NR*AW-1:0] redir_target_i = '0;
  logic             if_leave_i = 1'b0;

  logic          rv_o   [2];
  logic [AW-1:0] pc_o   [2];
  logic          adef_o [2];
  logic          ifv_o  [2];
  logic [AW-1:0] ifpc_o [2];
  logic [EW:0]   ifex_o [2];
  logic          ifst_o [2];
  logic          pend_o [2];

  pc_gen_unit #(.ADDR_W(AW), .RESET_PC(RPC), .FETCH_BYTES(4), .NUM_REDIR(NR), .EX_W(EW)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_o(rv_o[0]), .req_ready_i(req_ready_i), .req_pc_o(pc_o[0]), .req_adef_o(adef_o[0]),
    .inst_ex_i(inst_ex_i), .redir_valid_i(redir_valid_i), .redir_target_i(redir_target_i),
    .if_leave_i(if_leave_i), .if_valid_o(ifv_o[0]), .if_pc_o(ifpc_o[0]), .if_ex_o(ifex_o[0]),
    .if_stale_o(ifst_o[0]), .redir_pending_o(pend_o[0]));

  pc_gen_unit #(.ADDR_W(AW), .RESET_PC(RPC), .FETCH_BYTES(16), .NUM_REDIR(NR), .EX_W(EW)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_o(rv_o[1]), .req_ready_i(req_ready_i), .req_pc_o(pc_o[1]), .req_adef_o(adef_o[1]),
    .inst_ex_i(inst_ex_i), .redir_valid_i(redir_valid_i), .redir_target_i(redir_target_i),
    .if_leave_i(if_leave_i), .if_valid_o(ifv_o[1]), .if_pc_o(ifpc_o[1]), .if_ex_o(ifex_o[1]),
    .if_stale_o(ifst_o[1]), .redir_pending_o(pend_o[1]));

  // Reference model state, one set per instance.
  int unsigned m_fb [2] = '{4, 16};
  bit          m_rv [2];
  bit [AW-1:0] m_pc [2];
  bit          m_pv [2];
  int          m_pidx [2];
  bit [AW-1:0] m_ptgt [2];
  bit          m_ifv [2];
  bit [AW-1:0] m_ifpc [2];
  bit [EW:0]   m_ifex [2];
  bit          m_ifst [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rv[k] = 0; m_pc[k] = RPC; m_pv[k] = 0; m_pidx[k] = 0; m_ptgt[k] = '0;
      m_ifv[k] = 0; m_ifpc[k] = '0; m_ifex[k] = '0; m_ifst[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit          fire;
      int          sel;
      bit [AW-1:0] tgt;
      fire = m_rv[k] && req_ready_i;
      sel  = -1;
      for (int i = NR - 1; i >= 0; i--) if (redir_valid_i[i]) sel = i;
      tgt = (sel >= 0) ? redir_target_i[sel*AW +: AW] : '0;
      if (fire) begin
        m_ifv[k]  = 1;
        m_ifpc[k] = m_pc[k];
        m_ifex[k] = {(m_pc[k] % 4) != 0, inst_ex_i};
        m_ifst[k] = (sel >= 0) || m_pv[k];
        if (sel >= 0)    m_pc[k] = tgt;
        else if (m_pv[k]) m_pc[k] = m_ptgt[k];
        else             m_pc[k] = (m_pc[k] / m_fb[k]) * m_fb[k] + m_fb[k];
        m_pv[k] = 0;
      end else begin
        if (sel >= 0 && (!m_pv[k] || sel <= m_pidx[k])) begin
          m_pv[k] = 1; m_pidx[k] = sel; m_ptgt[k] = tgt;
        end
        if (if_leave_i) begin
          m_ifv[k] = 0; m_ifst[k] = 0;
        end
      end
      m_rv[k] = 1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_value($sformatf("d%0d req_valid", k), rv_o[k],   m_rv[k]);
      check_value($sformatf("d%0d req_pc", k),    pc_o[k],   m_pc[k]);
      check_value($sformatf("d%0d req_adef", k),  adef_o[k], (m_pc[k] % 4) != 0);
      check_value($sformatf("d%0d if_valid", k),  ifv_o[k],  m_ifv[k]);
      check_value($sformatf("d%0d if_pc", k),     ifpc_o[k], m_ifpc[k]);
      check_value($sformatf("d%0d if_ex", k),     ifex_o[k], m_ifex[k]);
      check_value($sformatf("d%0d if_stale", k),  ifst_o[k], m_ifst[k]);
      check_value($sformatf("d%0d pending", k),   pend_o[k], m_pv[k]);
    end
  endtask

  task automatic cycle();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic redir(input int ch, input logic [AW-1:0] tgt);
    redir_valid_i[ch] = 1'b1;
    redir_target_i[ch*AW +: AW] = tgt;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_all();
    @(posedge clk); #1;
    check_all();

    // Reset release with continuous ready.
    rst_n = 1'b1;
    req_ready_i = 1'b1;
    cycle();
    check_value("plan pc0", pc_o[0], 32'h1c000000);
    cycle();
    check_value("plan pc1", pc_o[0], 32'h1c000004);
    cycle();
    check_value("plan pc2", pc_o[0], 32'h1c000008);
    check_value("plan ifpc1", ifpc_o[0], 32'h1c000004);
    check_value("plan stale0", ifst_o[0], 1'b0);

    // Redirect coincident with fire.
    redir(1, 32'h1c000100);
    cycle();
    redir_valid_i = '0;
    check_value("redir pc", pc_o[0], 32'h1c000100);
    check_value("redir ifpc", ifpc_o[0], 32'h1c000008);
    check_value("redir stale", ifst_o[0], 1'b1);

    // Redirect during a stall is buffered.
    req_ready_i = 1'b0;
    redir(1, 32'h1c000200);
    cycle();
    redir_valid_i = '0;
    check_value("stall hold", pc_o[0], 32'h1c000100);
    check_value("stall pend", pend_o[0], 1'b1);
    cycle();
    cycle();
    req_ready_i = 1'b1;
    cycle();
    check_value("pend pc", pc_o[0], 32'h1c000200);
    check_value("pend ifpc", ifpc_o[0], 32'h1c000100);
    check_value("pend stale", ifst_o[0], 1'b1);

    // Priority inside the buffer.
    req_ready_i = 1'b0;
    redir(1, 32'h1c000200); cycle(); redir_valid_i = '0;
    redir(0, 32'h1c008000); cycle(); redir_valid_i = '0;
    redir(2, 32'h1c00f000); cycle(); redir_valid_i = '0;
    req_ready_i = 1'b1;
    cycle();
    check_value("prio pc", pc_o[0], 32'h1c008000);

    // Two channels together with fire.
    redir(0, 32'h1c001000);
    redir(1, 32'h1c002000);
    cycle();
    redir_valid_i = '0;
    check_value("dual pc", pc_o[0], 32'h1c001000);

    // Misaligned target on the 16-byte instance.
    redir(1, 32'h1c000106);
    cycle();
    redir_valid_i = '0;
    check_value("mis pc", pc_o[1], 32'h1c000106);
    check_value("mis adef", adef_o[1], 1'b1);
    inst_ex_i = 2'b01;
    cycle();
    inst_ex_i = '0;
    check_value("mis ifex", ifex_o[1], 3'b101);
    check_value("mis seq", pc_o[1], 32'h1c000110);

    // Asynchronous reset mid-cycle drops a pending redirect.
    req_ready_i = 1'b0;
    redir(2, 32'h1c00a000);
    cycle();
    redir_valid_i = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_value("async pend", pend_o[0], 1'b0);
    cycle();
    rst_n = 1'b1;

    // Randomized traffic, including near-wrap targets and occasional resets.
    for (int n = 0; n < 700; n++) begin
      req_ready_i   = ($urandom_range(0, 3) != 0);
      if_leave_i    = $urandom_range(0, 1);
      inst_ex_i     = EW'($urandom);
      redir_valid_i = '0;
      for (int c = 0; c < NR; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 9) == 0) redir(c, 32'hfffffff0 | AW'($urandom_range(0, 15)));
          else                           redir(c, 32'h1c000000 | AW'($urandom_range(0, 'hffff)));
        end
      end
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
      end else begin
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
